// File: rtl/serial_pkg.sv
// Shared state encoding and elaboration helpers for the serial deserializer.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// WIDTH-bit serial-in shift register; shifted_o is the next-state value
// including the bit presented this cycle, so a completed word is usable immediately.
module deser_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] shifted_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted_o = {data_q[WIDTH-2:0], serial_i};
    end else begin : g_lsb_first
      assign shifted_o = {serial_i, data_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    if (clear_i) begin
      data_d = '0;
    end else if (enable_i) begin
      data_d = shifted_o;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// Serial-in, parallel-out receiver with a double-buffered holding register
// and valid/ready output handshake; sticky overrun when a finished word is dropped.
module serial_deserializer
  import serial_pkg::*;
#(
  parameter int  WIDTH     = 8,
  parameter bit  MSB_FIRST = 1'b0,
  localparam int CNT_W     = clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             serial_in,
  input  logic             serial_en,
  input  logic             data_ready,
  input  logic             clear_overrun,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic             sr_clear;
  logic             sr_enable;
  logic [WIDTH-1:0] sr_word;
  logic             frame_done;
  logic             accept;
  logic             overrun_set;

  deser_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (sr_clear),
    .enable_i (sr_enable),
    .serial_i (serial_in),
    .shifted_o(sr_word)
  );

  // Frame FSM and bit counter; start always wins over a coincident strobe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_clear   = 1'b0;
    sr_enable  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d  = ST_SHIFT;
          sr_clear = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (start) begin
          cnt_d    = '0;
          sr_clear = 1'b1;
        end else if (serial_en) begin
          sr_enable = 1'b1;
          if (cnt_q == LAST_BIT) begin
            frame_done = 1'b1;
            cnt_d      = '0;
            state_d    = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register: a finished word lands only if the slot is free or being
  // drained this same cycle; otherwise it is dropped and flagged.
  always_comb begin
    accept      = valid_q & data_ready;
    hold_d      = hold_q;
    valid_d     = valid_q;
    overrun_set = 1'b0;
    if (frame_done) begin
      if (!valid_q || accept) begin
        hold_d  = sr_word;
        valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end

    overrun_d = overrun_q;
    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out   = hold_q;
  assign data_valid = valid_q;
  assign busy       = (state_q == ST_SHIFT);
  assign bit_count  = cnt_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: LSB-first and MSB-first instances share stimulus;
// accepted words are compared against a scoreboard of expected words.
module tb_serial_deserializer;

  logic       clock         = 1'b0;
  logic       reset         = 1'b0;
  logic       start         = 1'b0;
  logic       serial_in     = 1'b0;
  logic       serial_en     = 1'b0;
  logic       data_ready    = 1'b0;
  logic       clear_overrun = 1'b0;

  logic [7:0] l_data, m_data;
  logic       l_valid, m_valid, l_busy, m_busy, l_ovr, m_ovr;
  logic [2:0] l_cnt, m_cnt;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] q_lsb[$];
  logic [7:0] q_msb[$];

  always #5 clock = ~clock;

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .reset(reset), .start(start), .serial_in(serial_in),
    .serial_en(serial_en), .data_ready(data_ready), .clear_overrun(clear_overrun),
    .data_out(l_data), .data_valid(l_valid), .busy(l_busy),
    .bit_count(l_cnt), .overrun(l_ovr)
  );

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .reset(reset), .start(start), .serial_in(serial_in),
    .serial_en(serial_en), .data_ready(data_ready), .clear_overrun(clear_overrun),
    .data_out(m_data), .data_valid(m_valid), .busy(m_busy),
    .bit_count(m_cnt), .overrun(m_ovr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic b);
    serial_in = b;
    serial_en = 1'b1;
    tick();
    serial_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends bits lo..hi-1 of w, bit 0 first on the wire.
  task automatic send_bits(input logic [7:0] w, input int lo, input int hi);
    for (int i = lo; i < hi; i++) strobe(w[i]);
  endtask

  task automatic expect_word(input logic [7:0] w);
    q_lsb.push_back(w);
    q_msb.push_back(rev8(w));
  endtask

  // Scoreboard: a word is consumed whenever valid & ready meet at a posedge.
  always @(negedge clock) begin
    if (reset && l_valid && data_ready) begin
      if (q_lsb.size() == 0) begin
        check("sb_empty", 32'(q_lsb.size()), 32'd1);
      end else begin
        check("sb_lsb", 32'(l_data), 32'(q_lsb.pop_front()));
        check("sb_msb", 32'(m_data), 32'(q_msb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    check("rst_data",  32'(l_data),  32'h0);
    check("rst_valid", 32'(l_valid), 32'h0);
    check("rst_busy",  32'(l_busy),  32'h0);
    check("rst_cnt",   32'(l_cnt),   32'h0);
    check("rst_ovr",   32'(l_ovr),   32'h0);
    check("rst_mdata", 32'(m_data),  32'h0);
    reset = 1'b1;

    // First frame 4D, latency of exactly one cycle after the last strobe
    pulse_start();
    check("start_busy", 32'(l_busy), 32'h1);
    check("start_cnt",  32'(l_cnt),  32'h0);
    expect_word(8'h4D);
    send_bits(8'h4D, 0, 7);
    check("pre_cnt",   32'(l_cnt),   32'h7);
    check("pre_valid", 32'(l_valid), 32'h0);
    send_bits(8'h4D, 7, 8);
    check("f1_valid", 32'(l_valid), 32'h1);
    check("f1_data",  32'(l_data),  32'h4D);
    check("f1_mdata", 32'(m_data),  32'hB2);
    check("f1_mvalid", 32'(m_valid), 32'h1);
    check("f1_busy",  32'(l_busy),  32'h0);
    check("f1_cnt",   32'(l_cnt),   32'h0);

    // Overrun: FF completes with the slot still full
    pulse_start();
    send_bits(8'hFF, 0, 8);
    check("ovr_data",  32'(l_data),  32'h4D);
    check("ovr_mdata", 32'(m_data),  32'hB2);
    check("ovr_flag",  32'(l_ovr),   32'h1);
    check("ovr_mflag", 32'(m_ovr),   32'h1);
    tick();
    check("ovr_sticky", 32'(l_ovr), 32'h1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    check("clr_ovr",   32'(l_ovr),   32'h0);
    check("clr_valid", 32'(l_valid), 32'h1);

    // Accept in the same cycle a new word completes
    pulse_start();
    expect_word(8'h0F);
    send_bits(8'h0F, 0, 7);
    data_ready = 1'b1;
    send_bits(8'h0F, 7, 8);
    data_ready = 1'b0;
    check("swap_data",  32'(l_data),  32'h0F);
    check("swap_mdata", 32'(m_data),  32'hF0);
    check("swap_valid", 32'(l_valid), 32'h1);
    check("swap_ovr",   32'(l_ovr),   32'h0);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("drain_valid", 32'(l_valid), 32'h0);

    // Restart after 5 strobes; start beats a coincident strobe
    pulse_start();
    send_bits(8'hFF, 0, 5);
    check("part_cnt", 32'(l_cnt), 32'h5);
    start     = 1'b1;
    serial_en = 1'b1;
    serial_in = 1'b1;
    tick();
    start     = 1'b0;
    serial_en = 1'b0;
    check("restart_cnt",  32'(l_cnt),  32'h0);
    check("restart_busy", 32'(l_busy), 32'h1);
    expect_word(8'hA5);
    send_bits(8'hA5, 0, 8);
    check("a5_data",  32'(l_data),  32'hA5);
    check("a5_mdata", 32'(m_data),  32'hA5);
    check("a5_valid", 32'(l_valid), 32'h1);

    // Overrun set wins over a simultaneous clear
    pulse_start();
    send_bits(8'h3C, 0, 7);
    clear_overrun = 1'b1;
    send_bits(8'h3C, 7, 8);
    clear_overrun = 1'b0;
    check("setwin_ovr",  32'(l_ovr),  32'h1);
    check("setwin_data", 32'(l_data), 32'hA5);

    // Reset mid-frame with a word pending
    pulse_start();
    send_bits(8'h07, 0, 3);
    check("mid_cnt",   32'(l_cnt),   32'h3);
    check("mid_valid", 32'(l_valid), 32'h1);
    reset = 1'b0;
    tick();
    check("mrst_data",  32'(l_data),  32'h0);
    check("mrst_valid", 32'(l_valid), 32'h0);
    check("mrst_busy",  32'(l_busy),  32'h0);
    check("mrst_cnt",   32'(l_cnt),   32'h0);
    check("mrst_ovr",   32'(l_ovr),   32'h0);
    check("mrst_mbusy", 32'(m_busy),  32'h0);
    check("mrst_mcnt",  32'(m_cnt),   32'h0);
    q_lsb.delete();
    q_msb.delete();
    reset = 1'b1;

    // Strobes while idle are ignored
    send_bits(8'hFF, 0, 3);
    check("idle_cnt",  32'(l_cnt),  32'h0);
    check("idle_busy", 32'(l_busy), 32'h0);

    // Clean frame after reset, then drain it
    pulse_start();
    expect_word(8'h3C);
    send_bits(8'h3C, 0, 8);
    check("post_data", 32'(l_data), 32'h3C);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("post_valid", 32'(l_valid), 32'h0);
    tick();
    check("sb_left", 32'(q_lsb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Serial-in, parallel-out receiver. It is the receiving end of the team's 8-bit parallel-load/shift-right shifter, whose serial output leaves LSB first from bit 0.
- Collects WIDTH bits on qualified bit strobes and transfers the finished word to a holding register.
- Presents the word to the consumer with a valid/ready handshake.
- The double-buffered design lets the next frame shift in while the previous word waits.

Parameters:
- WIDTH, 8: bits per frame (range 2..32).
- MSB_FIRST, 0: bit order. 0 means the first received bit ends up in data_out[0] (shift right, insert at MSB). 1 means the first received bit ends up in data_out[WIDTH-1] (shift left, insert at bit 0).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-low.
- start  in  1  begin a new frame (clears bit count, discards any partial word).
- serial_in  in  1  serial data bit.
- serial_en  in  1  bit strobe; serial_in is sampled only on cycles where this is 1.
- data_ready  in  1  consumer accepts data_out this cycle.
- clear_overrun  in  1  clears the sticky overrun flag.
- data_out  out  WIDTH  last completed word.
- data_valid  out  1  data_out holds an unaccepted word.
- busy  out  1  frame in progress (state SHIFT).
- bit_count  out  CNT_W  bits received in the current frame.
- overrun  out  1  sticky: a completed word was dropped.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; shift_reg, data_out and bit_count = 0; data_valid, busy and overrun = 0. Reset overrides all other inputs, including mid-frame.
- IDLE:
  - start=1 -> SHIFT, bit_count=0, shift_reg=0.
  - serial_en is ignored in IDLE.
- SHIFT (busy=1):
  - Each cycle with serial_en=1: shift serial_in in per MSB_FIRST; bit_count+1.
  - start=1 in SHIFT restarts the frame: bit_count=0, shift_reg=0, partial bits lost. start takes priority over a coincident serial_en; that bit is dropped.
  - Frame completion is serial_en=1 with bit_count==WIDTH-1. On the next posedge:
    - the completed word, including the final bit, is presented to the holding register;
    - bit_count=0;
    - state goes to IDLE.
- Holding register / handshake:
  - Accept = data_valid & data_ready at posedge; accept clears data_valid.
  - Completion with data_valid=0: data_out=word, data_valid=1. Latency is 1 cycle from the final strobe to data_valid.
  - Completion with data_valid=1 and accept in the same cycle: data_out=new word, data_valid stays 1, no overrun.
  - Completion with data_valid=1 and no accept: new word is discarded, data_out unchanged, overrun=1.
  - data_out is stable while data_valid=1 and not accepted.
- overrun:
  - Stays set until clear_overrun=1 or reset.
  - If clear_overrun and a new overrun event occur in the same cycle, overrun ends at 1 (set wins).
- bit_count:
  - Never reaches WIDTH; it wraps to 0 at completion.
  - Reads 0 in IDLE.

Decomposition:
- Package serial_pkg holds:
  - state encoding constants ST_IDLE=2'd0 and ST_SHIFT=2'd1 (2'd2 and 2'd3 unused; they decode to IDLE on the next clock);
  - function clog2;
  - CNT_W = clog2(WIDTH).
- One sub-module, deser_shift_reg: a WIDTH-bit shift register with clear, enable, serial_in and a direction parameter.
- FSM, counter and holding/handshake logic stay in the top module.

Test Plan:
- Reset, then start, then 8 strobes with serial_in sequence 1,0,1,1,0,0,1,0 (MSB_FIRST=0) -> data_out=8'h4D, data_valid=1 exactly 1 cycle after the 8th strobe; busy=0, bit_count=0.
- Same sequence with MSB_FIRST=1 -> data_out=8'hB2.
- Hold data_ready=0, then complete a second frame carrying 8'hFF -> data_out stays 8'h4D, overrun=1. Then clear_overrun=1 -> overrun=0; data_valid still 1.
- data_ready=1 in the same cycle a new 8'h0F frame completes -> data_out=8'h0F, data_valid=1, overrun=0.
- start after 5 strobes, then 8 strobes of 8'hA5 -> data_out=8'hA5; the partial bits are not visible.
- Drive reset=0 mid-frame at bit_count=3 with data_valid=1 -> next cycle all outputs are 0 and state is IDLE. Also check that serial_en pulses in IDLE leave bit_count at 0.
